remap_mul_arb: RTL and testbench
================================

REMAP_MUL_ARB -- requirements
Module: remap_mul_arb

Interface
REQ-001 Parameter MUL_LAT, default 3, SHALL be the cycles from multiplier input capture to dout with ce high; fixed by the shared 11x11 multiplier.
REQ-002 ap_clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 ap_rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester k operand pair valid.
REQ-005 req0_ready / req1_ready  output  1  requester k operand pair accepted this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  11  unsigned operands.
REQ-007 rsp0_valid / rsp1_valid  output  1  product for requester k valid.
REQ-008 rsp0_ready / rsp1_ready  input  1  requester k accepts product.
REQ-009 rsp_p  output  22  unsigned product, shared by both response channels.
REQ-010 Block SHALL instantiate exactly one remap_accel_mul_mul_11ns_11ns_22_4_1, with din0/din1/ce/dout driven only by this block and its reset input tied to !ap_rst_n.

Function
REQ-011 Transfer on a channel SHALL occur when valid and ready are both high at a rising edge.
REQ-012 Pipeline tracker: MUL_LAT-deep shift register of {vld, tag}; tag 0/1 = owning requester.
REQ-013 Stall: stall = tail.vld && !rspN_ready (N = tail.tag); multiplier ce and tracker shift SHALL be !stall.
REQ-014 rspN_valid SHALL equal tail.vld && (tail.tag == N); rsp_p SHALL equal multiplier dout.
REQ-015 Issue SHALL occur only when !stall; at most one requester granted per cycle.
REQ-016 Arbitration: round-robin via last_grant bit; one valid requester SHALL be granted; both valid SHALL grant !last_grant; last_grant SHALL update only on a grant.
REQ-017 reqN_ready SHALL be combinational: !stall && grant==N && reqN_valid; never high for both.
REQ-018 On issue, din0/din1 SHALL be the granted a/b and tracker head SHALL load {1, N}; with no issue and !stall, head SHALL load vld=0.
REQ-019 Throughput: one issue per cycle sustained while no stall; product for an issue at edge t SHALL be presented from edge t+MUL_LAT, extended by stall cycles.
REQ-020 Results SHALL be delivered in issue order; none dropped or duplicated during stalls.
REQ-021 Simultaneous tail drain and new issue in one cycle SHALL both proceed.
REQ-022 Arithmetic: 11x11 unsigned, full 22-bit product, no truncation or saturation.

Reset
REQ-023 While ap_rst_n low: all tracker vld=0, last_grant=1 (requester 0 wins first tie), req*_ready=0, rsp*_valid=0.
REQ-024 Reset mid-operation SHALL discard in-flight products; no rsp*_valid SHALL assert for operands issued before reset.
REQ-025 Multiplier data registers need no reset; outputs are qualified only by tracker vld.

Configuration
REQ-026 Macro REMAP_MUL_ARB_STATS_EN defined: add outputs gnt_cnt0, gnt_cnt1 (16-bit each), incremented per issue to requester k, wrapping 0xFFFF->0, reset to 0.
REQ-027 Macro undefined: those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-028 Single: req0 a=2047,b=2047 one cycle, rsp ready high -> rsp0_valid exactly MUL_LAT cycles later, rsp_p=0x3FF001, rsp1_valid never high.
REQ-029 Contention: both valid 6 cycles, a=k+1,b=3 -> grants alternate 0,1,0,1,0,1 starting req0; products 3,6,... tagged correctly, in order.
REQ-030 Backpressure: stream 8 req0 ops, drop rsp0_ready for 5 cycles mid-stream -> req0_ready low while stalled, all 8 products delivered in order, none duplicated.
REQ-031 Cross-stall: tail tagged 1 with rsp1_ready low, req0 valid -> no issue, req0_ready low until rsp1 drains.
REQ-032 Reset: assert ap_rst_n low with 3 ops in flight -> no rsp*_valid after release; next tie grants req0.
REQ-033 Stats (macro defined): 70000 req1 issues -> gnt_cnt1 = 4464, gnt_cnt0 = 0.

Source files
------------

// File: rtl/remap_mul_arb.sv
// remap_mul_arb: two requesters share one pipelined 11x11 unsigned multiplier.
//   Ports: ap_clk, ap_rst_n (async, active-low)
//          req{0,1}_valid/_ready/_a/_b : operand request channels (ready is combinational)
//          rsp{0,1}_valid/_ready       : product response channels
//          rsp_p                       : 22-bit product shared by both response channels
//          gnt_cnt{0,1}                : 16-bit issue counters, present only with
//                                        REMAP_MUL_ARB_STATS_EN defined
// Round-robin arbitration; a MUL_LAT-deep {vld, tag} tracker mirrors the multiplier
// pipeline, and both are frozen while the tail result waits for its owner.

// Shared pipelined multiplier: input capture register plus NUM_STAGE-2 product stages.
module remap_accel_mul_mul_11ns_11ns_22_4_1 #(
   parameter int unsigned NUM_STAGE  = 4,
   parameter int unsigned din0_WIDTH = 11,
   parameter int unsigned din1_WIDTH = 11,
   parameter int unsigned dout_WIDTH = 22
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic [dout_WIDTH-1:0] dout
);
   localparam int unsigned PSTG = NUM_STAGE - 2;

   logic [din0_WIDTH-1:0] a_q;
   logic [din1_WIDTH-1:0] b_q;
   logic [dout_WIDTH-1:0] p_q [PSTG];

   // Data pipeline; contents are qualified downstream, reset only for tidiness.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q <= '0;
         b_q <= '0;
         for (int unsigned i = 0; i < PSTG; i++) p_q[i] <= '0;
      end else if (ce) begin
         a_q    <= din0;
         b_q    <= din1;
         p_q[0] <= dout_WIDTH'(a_q) * dout_WIDTH'(b_q);
         for (int unsigned i = 1; i < PSTG; i++) p_q[i] <= p_q[i-1];
      end
   end

   assign dout = p_q[PSTG-1];
endmodule

module remap_mul_arb #(
   parameter int unsigned MUL_LAT = 3
) (
   input  logic        ap_clk,
   input  logic        ap_rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [10:0] req0_a,
   input  logic [10:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [10:0] req1_a,
   input  logic [10:0] req1_b,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [21:0] rsp_p
`ifdef REMAP_MUL_ARB_STATS_EN
  ,output logic [15:0] gnt_cnt0,
   output logic [15:0] gnt_cnt1
`endif
);
   localparam int unsigned OPW = 11;
   localparam int unsigned PW  = 22;

   logic [MUL_LAT-1:0] vld_q, vld_d;
   logic [MUL_LAT-1:0] tag_q, tag_d;
   logic               last_grant_q;
   logic               tail_vld, tail_tag;
   logic               stall, grant, issue;
   logic [OPW-1:0]     mul_a, mul_b;
   logic [PW-1:0]      mul_dout;

   assign tail_vld = vld_q[MUL_LAT-1];
   assign tail_tag = tag_q[MUL_LAT-1];

   // Arbitration, stall and tracker next-state.
   always_comb begin
      stall = tail_vld && (tail_tag ? !rsp1_ready : !rsp0_ready);
      grant = 1'b0;
      if (req0_valid && req1_valid) grant = !last_grant_q;
      else if (req1_valid)          grant = 1'b1;
      issue      = ap_rst_n && !stall && (req0_valid || req1_valid);
      req0_ready = issue && !grant;
      req1_ready = issue && grant;
      mul_a      = grant ? req1_a : req0_a;
      mul_b      = grant ? req1_b : req0_b;
      vld_d      = {vld_q[MUL_LAT-2:0], issue};
      tag_d      = {tag_q[MUL_LAT-2:0], grant};
   end

   // Tracker and round-robin pointer; tracker shifts in lockstep with multiplier ce.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         vld_q        <= '0;
         tag_q        <= '0;
         last_grant_q <= 1'b1;
      end else begin
         if (!stall) begin
            vld_q <= vld_d;
            tag_q <= tag_d;
         end
         if (issue) last_grant_q <= grant;
      end
   end

   remap_accel_mul_mul_11ns_11ns_22_4_1 #(
      .NUM_STAGE  (MUL_LAT + 1),
      .din0_WIDTH (OPW),
      .din1_WIDTH (OPW),
      .dout_WIDTH (PW)
   ) u_mul (
      .clk   (ap_clk),
      .reset (!ap_rst_n),
      .ce    (!stall),
      .din0  (mul_a),
      .din1  (mul_b),
      .dout  (mul_dout)
   );

   assign rsp0_valid = tail_vld && !tail_tag;
   assign rsp1_valid = tail_vld && tail_tag;
   assign rsp_p      = mul_dout;

`ifdef REMAP_MUL_ARB_STATS_EN
   logic [15:0] gnt_cnt0_q, gnt_cnt1_q;

   // Per-requester issue counters, wrapping naturally at 16 bits.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         gnt_cnt0_q <= '0;
         gnt_cnt1_q <= '0;
      end else if (issue) begin
         if (grant) gnt_cnt1_q <= gnt_cnt1_q + 16'd1;
         else       gnt_cnt0_q <= gnt_cnt0_q + 16'd1;
      end
   end

   assign gnt_cnt0 = gnt_cnt0_q;
   assign gnt_cnt1 = gnt_cnt1_q;
`endif
endmodule

// File: tb/tb_remap_mul_arb.sv
// Directed bench for remap_mul_arb with a product scoreboard.
module tb_remap_mul_arb;
   localparam int unsigned MUL_LAT = 3;

   typedef struct packed {
      logic        tag;
      logic [21:0] p;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [10:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
   logic [21:0] rsp_p;
`ifdef REMAP_MUL_ARB_STATS_EN
   logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

   remap_mul_arb #(.MUL_LAT(MUL_LAT)) dut (
      .ap_clk     (clk),
      .ap_rst_n   (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rsp0_ready),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rsp1_ready),
      .rsp_p      (rsp_p)
`ifdef REMAP_MUL_ARB_STATS_EN
     ,.gnt_cnt0   (gnt_cnt0),
      .gnt_cnt1   (gnt_cnt1)
`endif
   );

   always #5 clk = ~clk;

   int   ncheck = 0, npass = 0;
   exp_t sb[$];
   int   glog[$];
   logic last_r0, last_r1, last_v0, last_v1;
   logic [21:0] last_p;
   int   n_v1 = 0, n_hs0 = 0, n_hs1 = 0;
   int   bad_both = 0, bad_rdy = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncheck++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic pop_cmp(input int k);
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_underflow", 32'(1), 32'(0));
      end else begin
         e = sb.pop_front();
         check("rsp_tag", 32'(k), 32'(e.tag));
         check("rsp_p", 32'(rsp_p), 32'(e.p));
      end
   endtask

   // One clock: sample mid-low-phase, record handshakes, then advance to next negedge.
   task automatic cycle();
      #1;
      last_r0 = req0_ready; last_r1 = req1_ready;
      last_v0 = rsp0_valid; last_v1 = rsp1_valid;
      last_p  = rsp_p;
      if (rsp0_valid && rsp1_valid) bad_both++;
      if (req0_ready && req1_ready) bad_rdy++;
      if (rsp1_valid) n_v1++;
      if (req0_valid && req0_ready) begin
         sb.push_back('{1'b0, 22'(req0_a) * 22'(req0_b)});
         glog.push_back(0);
      end
      if (req1_valid && req1_ready) begin
         sb.push_back('{1'b1, 22'(req1_a) * 22'(req1_b)});
         glog.push_back(1);
      end
      if (rsp0_valid && rsp0_ready) begin n_hs0++; pop_cmp(0); end
      if (rsp1_valid && rsp1_ready) begin n_hs1++; pop_cmp(1); end
      @(negedge clk);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      int n, idx, cnt, base;
      logic got;
      @(negedge clk);

      // Reset state with requests pending
      req0_valid = 1'b1; req1_valid = 1'b1;
      cycle(); cycle();
      check("rst_r0_ready", 32'(last_r0), 32'(0));
      check("rst_r1_ready", 32'(last_r1), 32'(0));
      check("rst_rsp0_valid", 32'(last_v0), 32'(0));
      check("rst_rsp1_valid", 32'(last_v1), 32'(0));
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst_n = 1'b1;
      cycle();

      // Contention: both valid six cycles, grants alternate from req0
      glog.delete();
      req0_a = 11'd1; req0_b = 11'd3; req1_a = 11'd2; req1_b = 11'd3;
      req0_valid = 1'b1; req1_valid = 1'b1;
      drain(6);
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("cont_ngrants", 32'(glog.size()), 32'(6));
      for (int i = 0; i < 6 && i < glog.size(); i++) check("cont_grant", 32'(glog[i]), 32'(i % 2));
      drain(6);
      check("cont_sb_empty", 32'(sb.size()), 32'(0));

      // Single max-operand product and its latency
      base = n_v1;
      req0_a = 11'd2047; req0_b = 11'd2047; req0_valid = 1'b1;
      cycle();
      check("single_ready", 32'(last_r0), 32'(1));
      req0_valid = 1'b0;
      n = 0; got = 1'b0;
      while (!got && n < 10) begin
         cycle(); n++;
         if (last_v0) got = 1'b1;
      end
      check("single_lat", 32'(n), 32'(MUL_LAT));
      check("single_p", 32'(last_p), 32'h3FF001);
      drain(4);
      check("single_no_rsp1", 32'(n_v1 - base), 32'(0));

      // Backpressure: 8 req0 ops, rsp0_ready low for 5 cycles mid-stream
      base = n_hs0; idx = 0;
      for (int c = 0; c < 30; c++) begin
         rsp0_ready = !(c >= 5 && c < 10);
         req0_valid = (idx < 8);
         req0_a = 11'(idx + 5); req0_b = 11'(idx * 7 + 1);
         cycle();
         if (last_v0 && !rsp0_ready && req0_valid) check("bp_ready_low", 32'(last_r0), 32'(0));
         if (last_r0 && req0_valid) idx++;
      end
      req0_valid = 1'b0; rsp0_ready = 1'b1;
      check("bp_issued", 32'(idx), 32'(8));
      check("bp_delivered", 32'(n_hs0 - base), 32'(8));
      check("bp_sb_empty", 32'(sb.size()), 32'(0));

      // Cross-stall: req1 result held at tail blocks req0
      rsp1_ready = 1'b0;
      req1_a = 11'd100; req1_b = 11'd200; req1_valid = 1'b1;
      cycle();
      req1_valid = 1'b0;
      n = 0; got = 1'b0;
      while (!got && n < 10) begin
         cycle(); n++;
         if (last_v1) got = 1'b1;
      end
      check("xs_tail_seen", 32'(got), 32'(1));
      req0_a = 11'd3; req0_b = 11'd4; req0_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("xs_r0_low", 32'(last_r0), 32'(0));
      end
      rsp1_ready = 1'b1;
      cycle();
      check("xs_drain_issue", 32'(last_r0), 32'(1));
      req0_valid = 1'b0;
      drain(6);
      check("xs_sb_empty", 32'(sb.size()), 32'(0));

      // Reset with 3 ops in flight
      for (int i = 0; i < 3; i++) begin
         req0_a = 11'(i + 1); req0_b = 11'd9; req0_valid = 1'b1;
         cycle();
      end
      rst_n = 1'b0;
      sb.delete();
      cycle();
      check("mid_rst_r0", 32'(last_r0), 32'(0));
      req0_valid = 1'b0;
      cycle();
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (last_v0 || last_v1) cnt++;
      end
      check("mid_rst_no_rsp", 32'(cnt), 32'(0));
      req0_a = 11'd5; req0_b = 11'd5; req1_a = 11'd6; req1_b = 11'd6;
      req0_valid = 1'b1; req1_valid = 1'b1;
      cycle();
      check("mid_rst_tie_r0", 32'(last_r0), 32'(1));
      check("mid_rst_tie_r1", 32'(last_r1), 32'(0));
      req0_valid = 1'b0; req1_valid = 1'b0;
      drain(6);
      check("mid_rst_sb_empty", 32'(sb.size()), 32'(0));

`ifdef REMAP_MUL_ARB_STATS_EN
      // Counter wrap: 70000 req1 issues
      rst_n = 1'b0; sb.delete();
      cycle();
      rst_n = 1'b1;
      cycle();
      check("st_cnt1_rst", 32'(gnt_cnt1), 32'(0));
      req1_a = 11'd7; req1_b = 11'd9; req1_valid = 1'b1;
      drain(70000);
      req1_valid = 1'b0;
      cycle();
      check("st_cnt1", 32'(gnt_cnt1), 32'(4464));
      check("st_cnt0", 32'(gnt_cnt0), 32'(0));
      drain(6);
      check("st_sb_empty", 32'(sb.size()), 32'(0));
`endif

      check("never_both_rsp", 32'(bad_both), 32'(0));
      check("never_both_ready", 32'(bad_rdy), 32'(0));
      $display("%0d/%0d checks passed", npass, ncheck);
      $finish;
   end
endmodule
